// File: rtl/snake_engine_param.sv
// ============================================================================
//  Module      : snake_engine_param
//  Description : Parametrised snake mover with food growth, wall/self
//                collision, optional wrap-around and step-gated movement.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module snake_engine_param #(
    parameter int GRID_W   = 16,
    parameter int GRID_H   = 16,
    parameter int MAX_LEN  = 32,
    parameter int INIT_LEN = 3,
    parameter int WRAP     = 0,
    localparam int XW = $clog2(GRID_W),
    localparam int YW = $clog2(GRID_H),
    localparam int SW = XW + YW,
    localparam int LW = $clog2(MAX_LEN + 1)
) (
    input  logic                  slw_clk,
    input  logic                  reset,
    input  logic                  step,
    input  logic                  up,
    input  logic                  down,
    input  logic                  left,
    input  logic                  right,
    input  logic                  food_valid,
    input  logic [XW-1:0]         food_x,
    input  logic [YW-1:0]         food_y,
    output logic [MAX_LEN*SW-1:0] body,
    output logic [LW-1:0]         length,
    output logic [XW-1:0]         head_x,
    output logic [YW-1:0]         head_y,
    output logic                  ate,
    output logic                  game_over,
    output logic                  body_valid
);

    typedef enum logic [0:0] {S_RUN = 1'b0, S_OVER = 1'b1} state_t;

    // Opposite directions differ only in bit 0
    localparam logic [1:0] c_dir_up    = 2'd0;
    localparam logic [1:0] c_dir_down  = 2'd1;
    localparam logic [1:0] c_dir_left  = 2'd2;
    localparam logic [1:0] c_dir_right = 2'd3;

    function automatic logic [MAX_LEN*SW-1:0] init_body();
        logic [MAX_LEN*SW-1:0] b;
        b = '0;
        for (int i = 0; i < INIT_LEN; i++)
            b[i*SW +: SW] = {YW'(1), XW'(INIT_LEN - i)};
        return b;
    endfunction

    state_t                r_state;
    logic [1:0]            r_dir;
    logic [1:0]            r_pend;
    logic [MAX_LEN*SW-1:0] r_body;
    logic [LW-1:0]         r_length;
    logic                  r_ate;
    logic                  r_game_over;
    logic                  r_body_valid;

    logic                  w_move;
    logic                  w_req_valid;
    logic [1:0]            w_req;
    logic [1:0]            w_dir_eff;
    logic [1:0]            w_pend_next;
    logic [XW-1:0]         w_hx, w_nx;
    logic [YW-1:0]         w_hy, w_ny;
    logic                  w_off;
    logic                  w_wall;
    logic                  w_grow;
    logic                  w_self;
    logic [SW-1:0]         w_nh;
    logic [LW-1:0]         w_chk_len;
    logic [LW-1:0]         w_new_len;
    logic [MAX_LEN*SW-1:0] w_shift;
    logic [MAX_LEN*SW-1:0] w_next_body;

    assign w_move = (r_state == S_RUN) && step;
    assign w_hx   = r_body[XW-1:0];
    assign w_hy   = r_body[SW-1:XW];

    always_comb begin
        w_req_valid = up | down | left | right;
        w_req       = c_dir_right;
        if (up)        w_req = c_dir_up;
        else if (down) w_req = c_dir_down;
        else if (left) w_req = c_dir_left;
        // Reversal is judged against the direction in force after this cycle
        w_dir_eff   = w_move ? r_pend : r_dir;
        w_pend_next = r_pend;
        if (w_req_valid && (w_req != (w_dir_eff ^ 2'b01)))
            w_pend_next = w_req;

        w_nx  = w_hx;
        w_ny  = w_hy;
        w_off = 1'b0;
        case (r_pend)
            c_dir_up: begin
                if (w_hy == '0) begin w_off = 1'b1; w_ny = YW'(GRID_H - 1); end
                else w_ny = w_hy - YW'(1);
            end
            c_dir_down: begin
                if (w_hy == YW'(GRID_H - 1)) begin w_off = 1'b1; w_ny = '0; end
                else w_ny = w_hy + YW'(1);
            end
            c_dir_left: begin
                if (w_hx == '0) begin w_off = 1'b1; w_nx = XW'(GRID_W - 1); end
                else w_nx = w_hx - XW'(1);
            end
            default: begin
                if (w_hx == XW'(GRID_W - 1)) begin w_off = 1'b1; w_nx = '0; end
                else w_nx = w_hx + XW'(1);
            end
        endcase
        w_wall = w_off && (WRAP == 0);
        w_nh   = {w_ny, w_nx};
        w_grow = food_valid && (w_nx == food_x) && (w_ny == food_y);

        // When growing the tail stays put, so it counts as an obstacle
        w_chk_len = w_grow ? r_length : r_length - LW'(1);
        w_self    = 1'b0;
        for (int i = 0; i < MAX_LEN; i++)
            if ((LW'(i) < w_chk_len) && (r_body[i*SW +: SW] == w_nh))
                w_self = 1'b1;

        w_new_len = (w_grow && (r_length < LW'(MAX_LEN))) ? r_length + LW'(1) : r_length;
        w_shift   = {r_body[(MAX_LEN-1)*SW-1:0], w_nh};
        for (int i = 0; i < MAX_LEN; i++)
            w_next_body[i*SW +: SW] = (LW'(i) < w_new_len) ? w_shift[i*SW +: SW] : '0;
    end

    always_ff @(posedge slw_clk) begin
        if (reset) begin
            r_state      <= S_RUN;
            r_dir        <= c_dir_right;
            r_pend       <= c_dir_right;
            r_body       <= init_body();
            r_length     <= LW'(INIT_LEN);
            r_ate        <= 1'b0;
            r_game_over  <= 1'b0;
            r_body_valid <= 1'b1;
        end else begin
            r_ate        <= 1'b0;
            r_body_valid <= 1'b0;
            r_pend       <= w_pend_next;
            if (w_move) begin
                r_dir <= r_pend;
                if (w_wall || w_self) begin
                    r_game_over <= 1'b1;
                    r_state     <= S_OVER;
                end else begin
                    r_body       <= w_next_body;
                    r_length     <= w_new_len;
                    r_ate        <= w_grow;
                    r_body_valid <= 1'b1;
                end
            end
        end
    end

    assign body       = r_body;
    assign length     = r_length;
    assign head_x     = r_body[XW-1:0];
    assign head_y     = r_body[SW-1:XW];
    assign ate        = r_ate;
    assign game_over  = r_game_over;
    assign body_valid = r_body_valid;

endmodule

`default_nettype wire

// File: tb/tb_snake_engine_param.sv
// ============================================================================
//  Module      : tb_snake_engine_param
//  Description : Directed scoreboard bench for snake_engine_param (no-wrap
//                instance plus a wrapping, length-capped instance).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snake_engine_param;

    logic         slw_clk = 1'b0;
    logic         reset = 1'b0, step = 1'b0;
    logic         up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
    logic         food_valid = 1'b0;
    logic [3:0]   food_x = '0, food_y = '0;
    logic [255:0] body;
    logic [5:0]   length;
    logic [3:0]   head_x, head_y;
    logic         ate, game_over, body_valid;

    logic         reset_w = 1'b0, step_w = 1'b0, nodir = 1'b0;
    logic         food_valid_w = 1'b0;
    logic [3:0]   food_x_w = '0, food_y_w = '0;
    logic [31:0]  body_w;
    logic [2:0]   length_w;
    logic [3:0]   head_x_w, head_y_w;
    logic         ate_w, game_over_w, body_valid_w;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int    inst;
        string tag;
        int    hx, hy, len, a, g, v;
    } exp_t;
    exp_t sb[$];

    always #5 slw_clk = ~slw_clk;

    snake_engine_param #(.GRID_W(16), .GRID_H(16), .MAX_LEN(32), .INIT_LEN(3), .WRAP(0)) dut (
        .slw_clk(slw_clk), .reset(reset), .step(step),
        .up(up), .down(down), .left(left), .right(right),
        .food_valid(food_valid), .food_x(food_x), .food_y(food_y),
        .body(body), .length(length), .head_x(head_x), .head_y(head_y),
        .ate(ate), .game_over(game_over), .body_valid(body_valid)
    );

    snake_engine_param #(.GRID_W(16), .GRID_H(16), .MAX_LEN(4), .INIT_LEN(3), .WRAP(1)) dut_w (
        .slw_clk(slw_clk), .reset(reset_w), .step(step_w),
        .up(nodir), .down(nodir), .left(nodir), .right(nodir),
        .food_valid(food_valid_w), .food_x(food_x_w), .food_y(food_y_w),
        .body(body_w), .length(length_w), .head_x(head_x_w), .head_y(head_y_w),
        .ate(ate_w), .game_over(game_over_w), .body_valid(body_valid_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_next();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL sb_empty: observed 0 entries expected 1");
            return;
        end
        e = sb.pop_front();
        if (e.inst == 0) begin
            chk({e.tag, "_hx"}, 32'(head_x), e.hx);
            chk({e.tag, "_hy"}, 32'(head_y), e.hy);
            chk({e.tag, "_len"}, 32'(length), e.len);
            chk({e.tag, "_ate"}, 32'(ate), e.a);
            chk({e.tag, "_go"}, 32'(game_over), e.g);
            chk({e.tag, "_bv"}, 32'(body_valid), e.v);
        end else begin
            chk({e.tag, "_hx"}, 32'(head_x_w), e.hx);
            chk({e.tag, "_hy"}, 32'(head_y_w), e.hy);
            chk({e.tag, "_len"}, 32'(length_w), e.len);
            chk({e.tag, "_ate"}, 32'(ate_w), e.a);
            chk({e.tag, "_go"}, 32'(game_over_w), e.g);
            chk({e.tag, "_bv"}, 32'(body_valid_w), e.v);
        end
    endtask

    // One clock: drive step, queue the expected outcome, check it after the edge
    task automatic cyc(input int inst, input bit st, input string tag,
                       input int hx, input int hy, input int len,
                       input int a, input int g, input int v);
        exp_t e;
        if (inst == 0) step = st; else step_w = st;
        e.inst = inst; e.tag = tag; e.hx = hx; e.hy = hy;
        e.len = len; e.a = a; e.g = g; e.v = v;
        sb.push_back(e);
        @(posedge slw_clk); #1;
        step = 1'b0; step_w = 1'b0; reset = 1'b0; reset_w = 1'b0;
        check_next();
    endtask

    task automatic press(input int d);
        up = (d == 0); down = (d == 1); left = (d == 2); right = (d == 3);
        @(posedge slw_clk); #1;
        up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    endtask

    task automatic chk_seg(input string tag, input int idx, input int x, input int y);
        logic [7:0] seg;
        seg = body[idx*8 +: 8];
        chk(tag, 32'(seg), 32'((y << 4) | x));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge slw_clk);
        reset = 1'b1; reset_w = 1'b1;
        cyc(0, 0, "rst", 3, 1, 3, 0, 0, 1);
        chk_seg("rst_seg0", 0, 3, 1);
        chk_seg("rst_seg1", 1, 2, 1);
        chk_seg("rst_seg2", 2, 1, 1);
        chk_seg("rst_seg3", 3, 0, 0);
        cyc(0, 0, "idle", 3, 1, 3, 0, 0, 0);

        for (int k = 1; k <= 4; k++)
            cyc(0, 1, $sformatf("run%0d", k), 3 + k, 1, 3, 0, 0, 1);
        chk_seg("run_tail", 2, 5, 1);

        press(2);
        cyc(0, 1, "rev_drop", 8, 1, 3, 0, 0, 1);

        press(0);
        cyc(0, 1, "up", 8, 0, 3, 0, 0, 1);
        cyc(0, 1, "wall", 8, 0, 3, 0, 1, 0);
        cyc(0, 1, "frozen", 8, 0, 3, 0, 1, 0);
        chk_seg("frozen_seg2", 2, 7, 1);

        reset = 1'b1;
        cyc(0, 1, "rst_mid", 3, 1, 3, 0, 0, 1);
        chk_seg("rst_mid_seg2", 2, 1, 1);

        food_valid = 1'b1; food_x = 4'd4; food_y = 4'd1;
        cyc(0, 1, "eat1", 4, 1, 4, 1, 0, 1);
        food_valid = 1'b0;
        chk_seg("eat1_tail", 3, 1, 1);
        cyc(0, 1, "post_eat", 5, 1, 4, 0, 0, 1);
        food_valid = 1'b1; food_x = 4'd6; food_y = 4'd1;
        cyc(0, 1, "eat2", 6, 1, 5, 1, 0, 1);
        food_valid = 1'b0;
        press(1);
        cyc(0, 1, "loop_dn", 6, 2, 5, 0, 0, 1);
        press(2);
        cyc(0, 1, "loop_lf", 5, 2, 5, 0, 0, 1);
        press(0);
        food_valid = 1'b1; food_x = 4'd5; food_y = 4'd1;
        cyc(0, 1, "self_hit", 5, 2, 5, 0, 1, 0);
        food_valid = 1'b0;
        cyc(0, 1, "self_frozen", 5, 2, 5, 0, 1, 0);

        for (int k = 1; k <= 13; k++)
            cyc(1, 1, $sformatf("wrap%0d", k), (3 + k) % 16, 1, 3, 0, 0, 1);
        food_valid_w = 1'b1; food_x_w = 4'd1; food_y_w = 4'd1;
        cyc(1, 1, "w_eat", 1, 1, 4, 1, 0, 1);
        food_x_w = 4'd2;
        cyc(1, 1, "w_cap", 2, 1, 4, 1, 0, 1);
        food_valid_w = 1'b0;
        cyc(1, 1, "w_after", 3, 1, 4, 0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
